mac_job_sched: RTL

Scheduler that shares one mac datapath (3-stage: operand regs, pipe regs, accumulate) between two requesters. It performs round-robin arbitration over dot-product jobs and streams operand pairs into the mac. It sequences MUL/MAC/SAT instructions in 16-bit or dual 8-bit mode and stalls the mac when operands are late. Once the pipeline has drained, it returns the saturated result to the winning requester.

---
 rtl/mac_job_sched.sv | 87 ++++++++
 1 files changed

// File: rtl/mac_job_sched.sv
// mac_job_sched: round-robin dot-product job scheduler sharing one 3-stage mac between two requesters
module mac_job_sched #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       req_mode,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       gnt,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [2:0]       mac_instruction,
  output logic [15:0]      mac_multiplier,
  output logic [15:0]      mac_multiplicand,
  output logic             mac_stall,
  input  logic [31:0]      mac_result,
  output logic             done,
  output logic             done_id,
  output logic [31:0]      done_result
);
  localparam int SW = $clog2(MAC_LAT + 1);
  typedef enum logic [2:0] {IDLE, CLR, STREAM, SAT, DONE} state_t;
  state_t state, state_nx;
  logic mode, rr_last, win, accept, done_id_q;
  logic [LEN_W-1:0] len, cnt, win_len;
  logic [SW-1:0] sat_cnt;
  logic [31:0] result_q;
  logic [1:0] op_code;
  assign win = &req ? ~rr_last : req[1];
  assign win_len = win ? req_len1 : req_len0;
  assign accept = state == STREAM && op_valid;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |req ? (win_len == '0 ? CLR : STREAM) : IDLE;
      CLR:     state_nx = SAT;
      STREAM:  state_nx = accept && cnt == len - LEN_W'(1) ? SAT : STREAM;
      SAT:     state_nx = sat_cnt == SW'(MAC_LAT - 1) ? DONE : SAT;
      default: state_nx = IDLE;
    endcase
  end
  // idle and done park the mac on SAT of the last mode; a stall freezes the whole mac pipe
  assign op_code = state == CLR ? 2'd0 : state == STREAM ? (cnt == '0 ? 2'd1 : 2'd2) : 2'd3;
  assign mac_instruction = {mode, op_code};
  assign mac_stall = !(state == CLR || state == SAT || accept);
  assign mac_multiplier = state == STREAM ? op_a : '0;
  assign mac_multiplicand = state == STREAM ? op_b : '0;
  assign op_ready = state == STREAM;
  assign busy = |gnt;
  assign done = state == DONE;
  assign done_id = done ? gnt[1] : done_id_q;
  assign done_result = done ? mac_result : result_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      mode      <= 1'b0;
      len       <= '0;
      cnt       <= '0;
      sat_cnt   <= '0;
      rr_last   <= 1'b1;
      done_id_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state   <= state_nx;
      sat_cnt <= state == SAT ? sat_cnt + SW'(1) : '0;
      if (state == IDLE && |req) begin
        gnt  <= win ? 2'b10 : 2'b01;
        mode <= req_mode[win];
        len  <= win_len;
        cnt  <= '0;
      end
      if (accept) cnt <= cnt + LEN_W'(1);
      if (done) begin
        gnt       <= '0;
        rr_last   <= gnt[1];
        done_id_q <= gnt[1];
        result_q  <= mac_result;
      end
    end
endmodule
